fixed_point_ln: RTL and testbench



---
 rtl/fixed_point_ln.sv | 141 ++++++++++++++
 tb/tb_fixed_point_ln.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_ln.sv
// Multi-cycle natural log for Q16.16 sign-magnitude operands.
// The operand is normalised, log2 is built one bit per cycle by squaring, and the result is scaled by ln2.
module fixed_point_ln #(
  parameter int N  = 32,
  parameter int Q  = 16,
  parameter int FB = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         out_err
);

  localparam int CW = $clog2(FB);
  localparam logic [N+Q-1:0] LN2 = (N+Q)'('hB172);

  // IDLE accept | NORM normalise | FRAC one log2 bit per cycle | SCALE times ln2 | DONE hold result
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_FRAC, S_SCALE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-2:0]  mag_q, mag_d;
  logic [N-1:0]  m_q, m_d;
  logic [5:0]    k_q, k_d;
  logic [FB-1:0] f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  y_q, y_d;
  logic          err_q, err_d;

  logic [4:0]    p;
  logic [N-1:0]  norm_m;
  logic [N-1:0]  sq;
  logic [N-1:0]  l_val;
  logic [N-1:0]  l_abs;
  logic [N-2:0]  y_s;
  logic [N-1:0]  y_res;

  always_comb begin
    p = '0;
    for (int i = 0; i < N-1; i++) begin
      if (mag_q[i]) p = 5'(i);
    end
  end

  assign norm_m = {1'b0, mag_q} << (5'(N-2) - p);
  assign sq     = N'(({{N{1'b0}}, m_q} * {{N{1'b0}}, m_q}) >> (N-2));

  // k is integer part, f the fraction; f sits directly in the Q fraction bits
  assign l_val  = {{(N-Q-6){k_q[5]}}, k_q, f_q};
  assign l_abs  = l_val[N-1] ? (~l_val + 1'b1) : l_val;
  assign y_s    = (N-1)'(({{Q{1'b0}}, l_abs} * LN2) >> Q);
  assign y_res  = {l_val[N-1] && (y_s != '0), y_s};

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    m_d     = m_q;
    k_d     = k_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mag_d = in_x[N-2:0];
          if (in_x[N-2:0] == '0) begin
            y_d     = '1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (in_x[N-1]) begin
            y_d     = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        m_d     = norm_m;
        k_d     = 6'(p) - 6'd16;
        f_d     = '0;
        cnt_d   = CW'(FB-1);
        state_d = S_FRAC;
      end
      S_FRAC: begin
        if (sq[N-1]) begin
          f_d = {f_q[FB-2:0], 1'b1};
          m_d = sq >> 1;
        end else begin
          f_d = {f_q[FB-2:0], 1'b0};
          m_d = sq;
        end
        if (cnt_q == '0) state_d = S_SCALE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SCALE: begin
        y_d     = y_res;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      m_q     <= '0;
      k_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      m_q     <= m_d;
      k_q     <= k_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_y     = y_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_fixed_point_ln.sv
// Scoreboard bench for fixed_point_ln: expected results queued at issue, observed results queued at handoff.
`timescale 1ns/1ps
module tb_fixed_point_ln;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_err;

  typedef struct packed {
    logic        err;
    logic [31:0] y;
    logic [7:0]  tol;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] obs_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int hs_cnt = 0;

  fixed_point_ln #(.N(32), .Q(16), .FB(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (in_valid && in_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      hs_cnt = hs_cnt + 1;
      obs_q.push_back({out_err, out_y});
    end
  end

  // Drive an operand until accepted; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] x, output bit ok);
    int a0;
    a0 = acc_cnt;
    ok = 1'b0;
    in_valid = 1'b1;
    in_x = x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Latency counts the accepting edge as edge 1; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_x = 32'h0001_0000;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_y !== 32'h0) begin n_bad++; $display("FAIL reset_out_y got %h want 00000000", out_y); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %b want 0", out_err); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_low got %b want 0", in_ready); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_valid_ops();
    logic [31:0] xs  [8] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0004_0000,
                             32'h0000_4000, 32'h0000_0001, 32'h0002_B7E1, 32'h7FFF_FFFF};
    logic [31:0] ys  [8] = '{32'h0000_0000, 32'h0000_B172, 32'h8000_B172, 32'h0001_62E4,
                             32'h8001_62E4, 32'h800B_1720, 32'h0001_0000, 32'h000A_65AF};
    logic [7:0]  tls [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd4};
    exp_t e;
    logic [32:0] o;
    int lat, d;
    bit ok;
    for (int t = 0; t < 8; t++) begin
      exp_q.push_back('{err: 1'b0, y: ys[t], tol: tls[t]});
      issue(xs[t], ok);
      if (ok) wait_valid(lat);
      else lat = -2;
      n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL valid_latency x=%h got %0d want 19", xs[t], lat); end
      handoff();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL valid_result x=%h got none want %h", xs[t], e.y);
      end else begin
        o = obs_q.pop_front();
        d = int'(o[30:0]) - int'(e.y[30:0]);
        if (d < 0) d = -d;
        if (o[32] !== e.err || o[31] !== e.y[31] || d > int'(e.tol)) begin
          n_bad++;
          $display("FAIL valid_result x=%h got y=%h err=%b want y=%h(+-%0d) err=%b", xs[t], o[31:0], o[32], e.y, e.tol, e.err);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] xs [4] = '{32'h0000_0000, 32'h8000_0000, 32'h8001_0000, 32'hFFFF_FFFF};
    logic [31:0] ys [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    exp_t e;
    logic [32:0] o;
    int lat;
    bit ok;
    for (int t = 0; t < 4; t++) begin
      exp_q.push_back('{err: 1'b1, y: ys[t], tol: 8'd0});
      issue(xs[t], ok);
      if (ok) wait_valid(lat);
      else lat = -2;
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL err_latency x=%h got %0d want 1", xs[t], lat); end
      handoff();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL err_result x=%h got none want %h", xs[t], e.y);
      end else begin
        o = obs_q.pop_front();
        if (o !== {e.err, e.y}) begin
          n_bad++; $display("FAIL err_result x=%h got y=%h err=%b want y=%h err=1", xs[t], o[31:0], o[32], e.y);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [32:0] o;
    int lat, h0, a0;
    bit ok;
    exp_q.push_back('{err: 1'b0, y: 32'h0000_B172, tol: 8'd0});
    issue(32'h0002_0000, ok);
    if (ok) wait_valid(lat);
    else lat = -2;
    n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL bp_latency got %0d want 19", lat); end
    h0 = hs_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_x = i[0] ? 32'h0000_8000 : 32'h7FFF_FFFF;
      out_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_y !== 32'h0000_B172 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle=%0d got v=%b y=%h e=%b rdy=%b want v=1 y=0000b172 e=0 rdy=0", i, out_valid, out_y, out_err, in_ready);
      end
    end
    in_x = 32'h0001_0000;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (hs_cnt - h0 !== 1) begin n_bad++; $display("FAIL bp_handoffs got %0d want 1", hs_cnt - h0); end
    n_cmp++; if (acc_cnt !== a0) begin n_bad++; $display("FAIL bp_no_accept got %0d want 0", acc_cnt - a0); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after got %b want 1", in_ready); end
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_q.size() == 0) begin
      n_bad++; $display("FAIL bp_result got none want %h", e.y);
    end else begin
      o = obs_q.pop_front();
      if (o !== {e.err, e.y}) begin n_bad++; $display("FAIL bp_result got %h want %h", o, {e.err, e.y}); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [32:0] o;
    int lat, h0;
    bit ok, seen;
    issue(32'h0002_0000, ok);
    repeat (8) @(negedge clk);
    h0 = hs_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_in_ready got %b want 0", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after got %b want 1", in_ready); end
    seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++; if (seen !== 1'b0 || hs_cnt != h0) begin n_bad++; $display("FAIL rmid_no_output got valid=%b handoffs=%0d want 0", seen, hs_cnt - h0); end
    exp_q.push_back('{err: 1'b0, y: 32'h8000_B172, tol: 8'd0});
    issue(32'h0000_8000, ok);
    if (ok) wait_valid(lat);
    else lat = -2;
    n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL rmid_latency got %0d want 19", lat); end
    handoff();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_q.size() == 0) begin
      n_bad++; $display("FAIL rmid_result got none want %h", e.y);
    end else begin
      o = obs_q.pop_front();
      if (o !== {e.err, e.y}) begin n_bad++; $display("FAIL rmid_result got %h want %h", o, {e.err, e.y}); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [32:0] o;
    int h0, a0, c0;
    bit ok;
    h0 = hs_cnt;
    out_ready = 1'b1;
    exp_q.push_back('{err: 1'b0, y: 32'h0001_62E4, tol: 8'd0});
    exp_q.push_back('{err: 1'b0, y: 32'h0000_0000, tol: 8'd0});
    issue(32'h0004_0000, ok);
    c0 = acc_cyc;
    a0 = acc_cnt;
    in_valid = 1'b1;
    in_x = 32'h0001_0000;
    for (int i = 0; i < 100 && acc_cnt == a0; i++) @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (!ok || acc_cnt == a0 || acc_cyc - c0 != 20) begin n_bad++; $display("FAIL b2b_spacing got %0d want 20", acc_cyc - c0); end
    for (int i = 0; i < 100 && hs_cnt - h0 < 2; i++) @(negedge clk);
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_result%0d got none want %h", t, e.y);
      end else begin
        o = obs_q.pop_front();
        if (o !== {e.err, e.y}) begin n_bad++; $display("FAIL b2b_result%0d got %h want %h", t, o, {e.err, e.y}); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_valid_ops();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
